// File: rtl/vid_sram_arb_if.sv
// vid_sram_arb_if: CPU memory port, video word-request port and SRAM pins.
// slave = arbiter side, master = CPU / display / SRAM side.
interface vid_sram_arb_if #(
  parameter int AW = 18
);
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_adr;
  logic [3:0]    cpu_be;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;
  logic          vid_req;
  logic [AW-1:0] vid_adr;
  logic [31:0]   vid_data;
  logic          vid_valid;
  logic          vid_ovr;
  logic          vid_ovr_clr;
  logic [AW-1:0] sram_adr;
  logic [31:0]   sram_wdata;
  logic          sram_wdata_en;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;
  logic [31:0]   sram_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_adr, cpu_be, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  vid_req, vid_adr, vid_ovr_clr,
    output vid_data, vid_valid, vid_ovr,
    output sram_adr, sram_wdata, sram_wdata_en,
    output sram_oe_n, sram_we_n, sram_be_n,
    input  sram_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_adr, cpu_be, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output vid_req, vid_adr, vid_ovr_clr,
    input  vid_data, vid_valid, vid_ovr,
    input  sram_adr, sram_wdata, sram_wdata_en,
    input  sram_oe_n, sram_we_n, sram_be_n,
    output sram_rdata
  );
endinterface

// File: rtl/vid_sram_arb.sv
// vid_sram_arb: one 32-bit async SRAM shared by video reads and CPU
// loads/stores. Ports: clk, rst (async, active low), bus (slave).
module vid_sram_arb #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  vid_sram_arb_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    VRD,
    CRD,
    CWR1,
    CWR2
  } state_t;

  state_t        st;
  state_t        nxt;
  logic          vid_pend;
  logic [AW-1:0] vid_adr_q;
  logic          vid_any;
  logic          cpu_ok;
  logic          ovr_set;

  // A held request must not be taken again in the cycle its ack shows.
  always_comb begin
    vid_any = bus.vid_req | vid_pend;
    cpu_ok  = ~bus.cpu_ack & ((st == IDLE) | (st == VRD));
    ovr_set = bus.vid_req & vid_pend;
    nxt     = IDLE;
    if (st == CWR1)
      nxt = CWR2;
    else if (vid_any)
      nxt = VRD;
    else if (cpu_ok & bus.cpu_wr)
      nxt = CWR1;
    else if (cpu_ok & bus.cpu_rd)
      nxt = CRD;
  end

  assign bus.cpu_stall = (bus.cpu_rd | bus.cpu_wr) & ~bus.cpu_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st                <= IDLE;
      vid_pend          <= 1'b0;
      vid_adr_q         <= '0;
      bus.vid_ovr       <= 1'b0;
      bus.vid_valid     <= 1'b0;
      bus.vid_data      <= '0;
      bus.cpu_rdata     <= '0;
      bus.cpu_ack       <= 1'b0;
      bus.sram_adr      <= '0;
      bus.sram_wdata    <= '0;
      bus.sram_wdata_en <= 1'b0;
      bus.sram_oe_n     <= 1'b1;
      bus.sram_we_n     <= 1'b1;
      bus.sram_be_n     <= 4'hf;
    end else begin
      st <= nxt;

      if (bus.vid_req)
        vid_adr_q <= bus.vid_adr;

      if (nxt == VRD)
        vid_pend <= 1'b0;
      else if (bus.vid_req)
        vid_pend <= 1'b1;

      // A new overrun beats a coincident clear.
      if (ovr_set)
        bus.vid_ovr <= 1'b1;
      else if (bus.vid_ovr_clr)
        bus.vid_ovr <= 1'b0;

      bus.vid_valid <= (st == VRD);
      if (st == VRD)
        bus.vid_data <= bus.sram_rdata;
      if (st == CRD)
        bus.cpu_rdata <= bus.sram_rdata;
      bus.cpu_ack <= (st == CRD) | (st == CWR2);

      bus.sram_oe_n     <= 1'b1;
      bus.sram_we_n     <= 1'b1;
      bus.sram_be_n     <= 4'hf;
      bus.sram_wdata_en <= 1'b0;

      unique case (nxt)
        VRD: begin
          // A request arriving now goes straight to the pins.
          bus.sram_adr  <= bus.vid_req ? bus.vid_adr : vid_adr_q;
          bus.sram_oe_n <= 1'b0;
          bus.sram_be_n <= 4'h0;
        end
        CRD: begin
          bus.sram_adr  <= bus.cpu_adr;
          bus.sram_oe_n <= 1'b0;
          bus.sram_be_n <= 4'h0;
        end
        CWR1, CWR2: begin
          bus.sram_adr      <= bus.cpu_adr;
          bus.sram_wdata    <= bus.cpu_wdata;
          bus.sram_wdata_en <= 1'b1;
          bus.sram_be_n     <= ~bus.cpu_be;
          bus.sram_we_n     <= (nxt == CWR1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_sram_arb.sv
// tb_vid_sram_arb: self-checking bench for vid_sram_arb with an async
// SRAM model and expected-data queues for video and CPU reads.
module tb_vid_sram_arb;
  localparam int AW = 18;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   we_cnt;
  int   oe_cnt;
  logic [31:0] vq[$];
  logic [31:0] cq[$];
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] want;

  vid_sram_arb_if #(.AW(AW)) bus ();

  vid_sram_arb #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.sram_rdata = mem[bus.sram_adr];

  initial forever begin
    @(posedge clk);
    if (!bus.sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!bus.sram_be_n[b])
          mem[bus.sram_adr][8*b +: 8] = bus.sram_wdata[8*b +: 8];
  end

  initial forever begin
    @(negedge clk);
    if (!bus.sram_we_n) we_cnt++;
    if (!bus.sram_oe_n) oe_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(2);
    n_cmp++;
    if ({bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n, bus.sram_wdata_en} !== 7'b1111110) begin
      n_bad++;
      $display("FAIL rst_pins: got %b want 1111110", {bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n, bus.sram_wdata_en});
    end
    n_cmp++;
    if (bus.sram_adr !== 18'h0) begin
      n_bad++; $display("FAIL rst_adr: got %h want 0", bus.sram_adr);
    end
    n_cmp++;
    if ({bus.vid_data, bus.cpu_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL rst_data: got %h %h want 0 0", bus.vid_data, bus.cpu_rdata);
    end
    n_cmp++;
    if ({bus.cpu_ack, bus.vid_valid, bus.vid_ovr} !== 3'b000) begin
      n_bad++; $display("FAIL rst_flags: got %b want 000", {bus.cpu_ack, bus.vid_valid, bus.vid_ovr});
    end
    rst = 1'b1;
    tick(2);
    n_cmp++;
    if ({bus.sram_oe_n, bus.sram_we_n, bus.cpu_stall} !== 3'b110) begin
      n_bad++; $display("FAIL rst_idle: got %b want 110", {bus.sram_oe_n, bus.sram_we_n, bus.cpu_stall});
    end
  endtask

  task automatic test_idle_video;
    mem[18'h37fc0] = 32'ha5a5f00f;
    bus.vid_req = 1'b1;
    bus.vid_adr = 18'h37fc0;
    vq.push_back(32'ha5a5f00f);
    tick;
    bus.vid_req = 1'b0;
    n_cmp++;
    if ({bus.sram_oe_n, bus.sram_be_n, bus.sram_adr} !== {1'b0, 4'h0, 18'h37fc0}) begin
      n_bad++; $display("FAIL vrd_pins: got %b %b %h want 0 0000 37fc0", bus.sram_oe_n, bus.sram_be_n, bus.sram_adr);
    end
    n_cmp++;
    if (bus.vid_valid !== 1'b0) begin
      n_bad++; $display("FAIL vid_early: got %b want 0", bus.vid_valid);
    end
    tick;
    n_cmp++;
    if (bus.vid_valid !== 1'b1) begin
      n_bad++; $display("FAIL vid_lat2: got %b want 1", bus.vid_valid);
    end
    n_cmp++;
    if (vq.size() == 0) begin
      n_bad++; $display("FAIL vid_sb: got output want none");
    end else begin
      want = vq.pop_front();
      if (bus.vid_data !== want) begin
        n_bad++; $display("FAIL vid_data: got %h want %h", bus.vid_data, want);
      end
    end
    tick(3);
    n_cmp++;
    if ({bus.vid_valid, bus.vid_data} !== {1'b0, want}) begin
      n_bad++; $display("FAIL vid_hold: got %b %h want 0 %h", bus.vid_valid, bus.vid_data, want);
    end
  endtask

  task automatic test_write_read;
    int w0;
    mem[18'h10] = 32'haabbccdd;
    w0 = we_cnt;
    bus.cpu_wr    = 1'b1;
    bus.cpu_adr   = 18'h10;
    bus.cpu_be    = 4'b0110;
    bus.cpu_wdata = 32'h12345678;
    tick;
    n_cmp++;
    if ({bus.sram_we_n, bus.sram_wdata_en, bus.sram_be_n, bus.sram_oe_n, bus.cpu_stall} !== 8'b11100111) begin
      n_bad++;
      $display("FAIL cwr1_pins: got %b want 11100111", {bus.sram_we_n, bus.sram_wdata_en, bus.sram_be_n, bus.sram_oe_n, bus.cpu_stall});
    end
    n_cmp++;
    if ({bus.sram_adr, bus.sram_wdata} !== {18'h10, 32'h12345678}) begin
      n_bad++; $display("FAIL cwr1_bus: got %h %h want 00010 12345678", bus.sram_adr, bus.sram_wdata);
    end
    tick;
    n_cmp++;
    if ({bus.sram_we_n, bus.sram_be_n, bus.cpu_ack} !== 6'b010010) begin
      n_bad++; $display("FAIL cwr2_pins: got %b want 010010", {bus.sram_we_n, bus.sram_be_n, bus.cpu_ack});
    end
    tick;
    n_cmp++;
    if ({bus.cpu_ack, bus.sram_we_n, bus.cpu_stall} !== 3'b110) begin
      n_bad++; $display("FAIL wr_ack3: got %b want 110", {bus.cpu_ack, bus.sram_we_n, bus.cpu_stall});
    end
    bus.cpu_wr = 1'b0;
    tick;
    n_cmp++;
    if ({bus.cpu_ack, 32'(we_cnt - w0)} !== {1'b0, 32'd1}) begin
      n_bad++; $display("FAIL wr_once: got ack %b strobes %0d want 0 1", bus.cpu_ack, we_cnt - w0);
    end
    cq.push_back(32'haa3456dd);
    bus.cpu_rd = 1'b1;
    tick;
    n_cmp++;
    if ({bus.sram_oe_n, bus.sram_adr, bus.cpu_ack} !== {1'b0, 18'h10, 1'b0}) begin
      n_bad++; $display("FAIL crd_pins: got %b %h %b want 0 00010 0", bus.sram_oe_n, bus.sram_adr, bus.cpu_ack);
    end
    tick;
    n_cmp++;
    if (cq.size() == 0) begin
      n_bad++; $display("FAIL cpu_sb: got output want none");
    end else begin
      want = cq.pop_front();
      if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, want}) begin
        n_bad++; $display("FAIL rd_data: got %b %h want 1 %h", bus.cpu_ack, bus.cpu_rdata, want);
      end
    end
    bus.cpu_rd = 1'b0;
    tick;
    n_cmp++;
    if (bus.cpu_ack !== 1'b0) begin
      n_bad++; $display("FAIL rd_ack_pulse: got %b want 0", bus.cpu_ack);
    end
  endtask

  task automatic test_collision;
    mem[18'h100] = 32'h0badc0de;
    mem[18'h20]  = 32'h0;
    bus.cpu_wr    = 1'b1;
    bus.cpu_adr   = 18'h20;
    bus.cpu_be    = 4'hf;
    bus.cpu_wdata = 32'hcafef00d;
    tick;
    bus.vid_req = 1'b1;
    bus.vid_adr = 18'h100;
    vq.push_back(32'h0badc0de);
    tick;
    bus.vid_req = 1'b0;
    n_cmp++;
    if (bus.sram_we_n !== 1'b0) begin
      n_bad++; $display("FAIL col_we: got %b want 0", bus.sram_we_n);
    end
    tick;
    n_cmp++;
    if ({bus.sram_oe_n, bus.sram_we_n, bus.sram_adr, bus.cpu_ack} !== {1'b0, 1'b1, 18'h100, 1'b1}) begin
      n_bad++; $display("FAIL col_vrd: got %b %b %h %b want 0 1 00100 1", bus.sram_oe_n, bus.sram_we_n, bus.sram_adr, bus.cpu_ack);
    end
    bus.cpu_wr = 1'b0;
    tick;
    n_cmp++;
    if ({bus.vid_valid, bus.cpu_ack, bus.sram_wdata_en} !== 3'b100) begin
      n_bad++; $display("FAIL col_lat3: got %b want 100", {bus.vid_valid, bus.cpu_ack, bus.sram_wdata_en});
    end
    n_cmp++;
    if (vq.size() == 0) begin
      n_bad++; $display("FAIL col_sb: got output want none");
    end else begin
      want = vq.pop_front();
      if (bus.vid_data !== want) begin
        n_bad++; $display("FAIL col_data: got %h want %h", bus.vid_data, want);
      end
    end
    tick;
  endtask

  task automatic test_simultaneous;
    int o0;
    mem[18'h200] = 32'h11112222;
    o0 = oe_cnt;
    bus.vid_req = 1'b1;
    bus.vid_adr = 18'h200;
    bus.cpu_rd  = 1'b1;
    bus.cpu_adr = 18'h20;
    vq.push_back(32'h11112222);
    cq.push_back(32'hcafef00d);
    tick;
    bus.vid_req = 1'b0;
    n_cmp++;
    if ({bus.sram_oe_n, bus.sram_adr, bus.cpu_ack} !== {1'b0, 18'h200, 1'b0}) begin
      n_bad++; $display("FAIL sim_vrd: got %b %h %b want 0 00200 0", bus.sram_oe_n, bus.sram_adr, bus.cpu_ack);
    end
    tick;
    n_cmp++;
    if ({bus.sram_oe_n, bus.sram_adr, bus.vid_valid} !== {1'b0, 18'h20, 1'b1}) begin
      n_bad++; $display("FAIL sim_crd: got %b %h %b want 0 00020 1", bus.sram_oe_n, bus.sram_adr, bus.vid_valid);
    end
    n_cmp++;
    if (vq.size() == 0) begin
      n_bad++; $display("FAIL sim_vsb: got output want none");
    end else begin
      want = vq.pop_front();
      if (bus.vid_data !== want) begin
        n_bad++; $display("FAIL sim_vdata: got %h want %h", bus.vid_data, want);
      end
    end
    tick;
    n_cmp++;
    if (cq.size() == 0) begin
      n_bad++; $display("FAIL sim_csb: got output want none");
    end else begin
      want = cq.pop_front();
      if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, want}) begin
        n_bad++; $display("FAIL sim_rd: got %b %h want 1 %h", bus.cpu_ack, bus.cpu_rdata, want);
      end
    end
    bus.cpu_rd = 1'b0;
    tick(3);
    n_cmp++;
    if ({bus.cpu_ack, 32'(oe_cnt - o0)} !== {1'b0, 32'd2}) begin
      n_bad++; $display("FAIL sim_reads: got ack %b reads %0d want 0 2", bus.cpu_ack, oe_cnt - o0);
    end
  endtask

  task automatic test_overrun;
    int o0;
    mem[18'h500] = 32'h55555555;
    mem[18'h600] = 32'h66666666;
    for (int r = 0; r < 2; r++) begin
      o0 = oe_cnt;
      bus.cpu_wr    = 1'b1;
      bus.cpu_adr   = 18'h40;
      bus.cpu_be    = 4'hf;
      bus.cpu_wdata = 32'h0;
      tick;
      bus.vid_req = 1'b1;
      bus.vid_adr = 18'h500;
      tick;
      n_cmp++;
      if (bus.vid_ovr !== 1'b0) begin
        n_bad++; $display("FAIL ovr_single%0d: got %b want 0", r, bus.vid_ovr);
      end
      bus.vid_adr     = 18'h600;
      bus.vid_ovr_clr = (r == 1);
      vq.push_back(32'h66666666);
      tick;
      bus.vid_req     = 1'b0;
      bus.vid_ovr_clr = 1'b0;
      bus.cpu_wr      = 1'b0;
      n_cmp++;
      if ({bus.vid_ovr, bus.sram_oe_n, bus.sram_adr} !== {1'b1, 1'b0, 18'h600}) begin
        n_bad++; $display("FAIL ovr_set%0d: got %b %b %h want 1 0 00600", r, bus.vid_ovr, bus.sram_oe_n, bus.sram_adr);
      end
      tick;
      n_cmp++;
      if (vq.size() == 0) begin
        n_bad++; $display("FAIL ovr_sb%0d: got output want none", r);
      end else begin
        want = vq.pop_front();
        if ({bus.vid_valid, bus.vid_data} !== {1'b1, want}) begin
          n_bad++; $display("FAIL ovr_data%0d: got %b %h want 1 %h", r, bus.vid_valid, bus.vid_data, want);
        end
      end
      tick(2);
      n_cmp++;
      if (oe_cnt - o0 !== 1) begin
        n_bad++; $display("FAIL ovr_vrds%0d: got %0d want 1", r, oe_cnt - o0);
      end
      bus.vid_ovr_clr = 1'b1;
      tick;
      bus.vid_ovr_clr = 1'b0;
      n_cmp++;
      if (bus.vid_ovr !== 1'b0) begin
        n_bad++; $display("FAIL ovr_clr%0d: got %b want 0", r, bus.vid_ovr);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++)
      mem[18'h700 + i] = 32'h70000000 + i;
    for (int k = 0; k < 6; k++) begin
      bus.vid_req = (k < 3);
      bus.vid_adr = 18'h700 + 18'(k);
      if (k < 3) vq.push_back(32'h70000000 + k);
      tick;
      n_cmp++;
      if (k + 1 >= 2 && k + 1 <= 4) begin
        if (vq.size() == 0) begin
          n_bad++; $display("FAIL b2b_sb%0d: got output want none", k);
        end else begin
          want = vq.pop_front();
          if ({bus.vid_valid, bus.vid_data} !== {1'b1, want}) begin
            n_bad++; $display("FAIL b2b_data%0d: got %b %h want 1 %h", k, bus.vid_valid, bus.vid_data, want);
          end
        end
      end else if (bus.vid_valid !== 1'b0) begin
        n_bad++; $display("FAIL b2b_valid%0d: got %b want 0", k, bus.vid_valid);
      end
    end
    bus.vid_req = 1'b0;
    n_cmp++;
    if (bus.vid_ovr !== 1'b0) begin
      n_bad++; $display("FAIL b2b_ovr: got %b want 0", bus.vid_ovr);
    end
  endtask

  task automatic test_reset_midwrite;
    int w0;
    mem[18'h50] = 32'h01020304;
    bus.cpu_wr    = 1'b1;
    bus.cpu_adr   = 18'h50;
    bus.cpu_be    = 4'hf;
    bus.cpu_wdata = 32'h99999999;
    tick(2);
    w0 = we_cnt;
    n_cmp++;
    if (bus.sram_we_n !== 1'b0) begin
      n_bad++; $display("FAIL rmw_cwr2: got %b want 0", bus.sram_we_n);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.sram_we_n, bus.sram_oe_n, bus.sram_be_n, bus.sram_wdata_en} !== 7'b1111110) begin
      n_bad++;
      $display("FAIL rmw_pins: got %b want 1111110", {bus.sram_we_n, bus.sram_oe_n, bus.sram_be_n, bus.sram_wdata_en});
    end
    n_cmp++;
    if ({bus.sram_adr, bus.vid_data, bus.cpu_rdata} !== {18'h0, 64'h0}) begin
      n_bad++; $display("FAIL rmw_regs: got %h %h %h want 0 0 0", bus.sram_adr, bus.vid_data, bus.cpu_rdata);
    end
    bus.cpu_wr = 1'b0;
    tick(2);
    n_cmp++;
    if ({bus.cpu_ack, bus.vid_valid, bus.vid_ovr} !== 3'b000) begin
      n_bad++; $display("FAIL rmw_noack: got %b want 000", {bus.cpu_ack, bus.vid_valid, bus.vid_ovr});
    end
    rst = 1'b1;
    tick(2);
    n_cmp++;
    if (we_cnt !== w0) begin
      n_bad++; $display("FAIL rmw_strobe: got %0d want %0d", we_cnt, w0);
    end
    cq.push_back(32'h01020304);
    bus.cpu_rd = 1'b1;
    tick;
    n_cmp++;
    if ({bus.sram_oe_n, bus.sram_adr} !== {1'b0, 18'h50}) begin
      n_bad++; $display("FAIL rmw_crd: got %b %h want 0 00050", bus.sram_oe_n, bus.sram_adr);
    end
    tick;
    n_cmp++;
    if (cq.size() == 0) begin
      n_bad++; $display("FAIL rmw_sb: got output want none");
    end else begin
      want = cq.pop_front();
      if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, want}) begin
        n_bad++; $display("FAIL rmw_rd: got %b %h want 1 %h", bus.cpu_ack, bus.cpu_rdata, want);
      end
    end
    bus.cpu_rd = 1'b0;
    tick;
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    we_cnt          = 0;
    oe_cnt          = 0;
    rst             = 1'b1;
    bus.cpu_rd      = 1'b0;
    bus.cpu_wr      = 1'b0;
    bus.cpu_adr     = '0;
    bus.cpu_be      = 4'h0;
    bus.cpu_wdata   = 32'h0;
    bus.vid_req     = 1'b0;
    bus.vid_adr     = '0;
    bus.vid_ovr_clr = 1'b0;
    #3 rst = 1'b0;
    test_reset;
    test_idle_video;
    test_write_read;
    test_collision;
    test_simultaneous;
    test_overrun;
    test_back_to_back;
    test_reset_midwrite;
    n_cmp++;
    if (vq.size() + cq.size() != 0) begin
      n_bad++; $display("FAIL sb_left: got %0d want 0", vq.size() + cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
